// File: rtl/debug_bus_master.sv
// Byte-stream debug bus master: decodes read/write frames from a host link,
// runs one strobe on the debug bus with timeout, and returns data or ACK/NAK.
module debug_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  dbg_a,
   output logic [15:0] dbg_di,
   input  logic [15:0] dbg_do,
   output logic        dbg_we,
   output logic        dbg_rd,
   input  logic        dbg_ready,
   output logic        busy
);

   localparam logic [7:0] CMD_RD = 8'h01;
   localparam logic [7:0] CMD_WR = 8'h02;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;
   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DHI, S_DLO, S_BUS, S_TX_HI, S_TX_LO, S_TX_ACK
   } state_t;

   state_t      state_q, state_d;
   logic        op_wr_q, op_wr_d;
   logic [7:0]  dbg_a_q, dbg_a_d;
   logic [15:0] dbg_di_q, dbg_di_d;
   logic        rd_q, rd_d;
   logic        we_q, we_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [15:0] hold_q, hold_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rx_fire;

   assign rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                     (state_q == S_DHI)  || (state_q == S_DLO);
   assign busy     = (state_q != S_IDLE);
   assign rx_fire  = rx_valid && rx_ready;

   always_comb begin
      state_d    = state_q;
      op_wr_d    = op_wr_q;
      dbg_a_d    = dbg_a_q;
      dbg_di_d   = dbg_di_q;
      rd_d       = rd_q;
      we_d       = we_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: if (rx_fire) begin
            if (rx_data == CMD_RD) begin
               op_wr_d = 1'b0;
               state_d = S_ADDR;
            end else if (rx_data == CMD_WR) begin
               op_wr_d = 1'b1;
               state_d = S_ADDR;
            end
         end
         S_ADDR: if (rx_fire) begin
            dbg_a_d = rx_data;
            if (op_wr_q) begin
               state_d = S_DHI;
            end else begin
               state_d = S_BUS;
               rd_d    = 1'b1;
               cnt_d   = 8'd0;
            end
         end
         S_DHI: if (rx_fire) begin
            dbg_di_d[15:8] = rx_data;
            state_d        = S_DLO;
         end
         S_DLO: if (rx_fire) begin
            dbg_di_d[7:0] = rx_data;
            state_d       = S_BUS;
            we_d          = 1'b1;
            cnt_d         = 8'd0;
         end
         S_BUS: begin
            // ready on the final allowed cycle still counts as completion
            if (dbg_ready) begin
               rd_d       = 1'b0;
               we_d       = 1'b0;
               tx_valid_d = 1'b1;
               if (op_wr_q) begin
                  tx_data_d = RSP_ACK;
                  state_d   = S_TX_ACK;
               end else begin
                  hold_d    = dbg_do;
                  tx_data_d = dbg_do[15:8];
                  state_d   = S_TX_HI;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
               if ({1'b0, cnt_q} + 9'd1 >= TO_LIMIT) begin
                  rd_d       = 1'b0;
                  we_d       = 1'b0;
                  tx_valid_d = 1'b1;
                  tx_data_d  = RSP_NAK;
                  state_d    = S_TX_ACK;
               end
            end
         end
         S_TX_HI: if (tx_ready) begin
            tx_data_d = hold_q[7:0];
            state_d   = S_TX_LO;
         end
         S_TX_LO, S_TX_ACK: if (tx_ready) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_wr_q    <= 1'b0;
         dbg_a_q    <= 8'h00;
         dbg_di_q   <= 16'h0000;
         rd_q       <= 1'b0;
         we_q       <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         hold_q     <= 16'h0000;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         op_wr_q    <= op_wr_d;
         dbg_a_q    <= dbg_a_d;
         dbg_di_q   <= dbg_di_d;
         rd_q       <= rd_d;
         we_q       <= we_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
      end
   end

   assign dbg_a    = dbg_a_q;
   assign dbg_di   = dbg_di_q;
   assign dbg_rd   = rd_q;
   assign dbg_we   = we_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_debug_bus_master.sv
// Frame-level bench for debug_bus_master: directed table, random frames vs.
// a transaction model, reset at power-up and in the middle of a bus strobe.
module tb_debug_bus_master;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  dbg_a;
   logic [15:0] dbg_di;
   logic [15:0] dbg_do;
   logic        dbg_we;
   logic        dbg_rd;
   logic        dbg_ready;
   logic        busy;

   debug_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .dbg_a(dbg_a), .dbg_di(dbg_di), .dbg_do(dbg_do),
      .dbg_we(dbg_we), .dbg_rd(dbg_rd), .dbg_ready(dbg_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Responder: ready on the rdy_at-th strobe cycle (0 = never).
   int          rdy_at = 0;
   logic [15:0] dout_v = 16'h0;
   logic [7:0]  scnt = 8'd0;
   always @(posedge clk) scnt <= (dbg_rd || dbg_we) ? scnt + 8'd1 : 8'd0;
   assign dbg_ready = (dbg_rd || dbg_we) && (rdy_at != 0) && (int'(scnt) == rdy_at - 1);
   assign dbg_do    = dout_v;

   // Protocol monitor
   int          rd_cyc, we_cyc, both_cnt, unstable, rxr_bad, txhold_bad;
   logic [7:0]  a_seen;
   logic [15:0] di_seen;
   logic        prev_strobe = 1'b0, prev_stall = 1'b0;
   logic [7:0]  prev_txd = 8'h0;
   logic [7:0]  tx_q[$];

   always @(negedge clk) begin
      if (dbg_rd) rd_cyc++;
      if (dbg_we) we_cyc++;
      if (dbg_rd && dbg_we) both_cnt++;
      if (dbg_rd || dbg_we) begin
         if (prev_strobe && (dbg_a !== a_seen || dbg_di !== di_seen)) unstable++;
         a_seen  = dbg_a;
         di_seen = dbg_di;
         if (rx_ready) rxr_bad++;
      end
      if (tx_valid && rx_ready) rxr_bad++;
      if (prev_stall && (!tx_valid || tx_data !== prev_txd)) txhold_bad++;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      prev_strobe = dbg_rd || dbg_we;
      prev_stall  = tx_valid && !tx_ready && !rst;
      prev_txd    = tx_data;
   end

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] data;
      int          rdy;
      logic [15:0] dout;
      int          stall;
      bit          garb;
      int          exp_n;
      logic [7:0]  exp0;
      logic [7:0]  exp1;
      int          exp_cyc;
   } vec_t;

   function automatic vec_t mk(logic wr, logic [7:0] addr, logic [15:0] data, int rdy,
                               logic [15:0] dout, int stall, bit garb, int n,
                               logic [7:0] e0, logic [7:0] e1, int cyc);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.rdy = rdy; v.dout = dout;
      v.stall = stall; v.garb = garb; v.exp_n = n; v.exp0 = e0; v.exp1 = e1;
      v.exp_cyc = cyc;
      return v;
   endfunction

   // Transaction model: responder answers within the budget or the master gives up.
   function automatic vec_t model(vec_t v);
      vec_t r = v;
      if (v.rdy >= 1 && v.rdy <= TO) begin
         r.exp_cyc = v.rdy;
         if (v.wr) begin
            r.exp_n = 1; r.exp0 = 8'h06; r.exp1 = 8'h00;
         end else begin
            r.exp_n = 2; r.exp0 = v.dout[15:8]; r.exp1 = v.dout[7:0];
         end
      end else begin
         r.exp_cyc = TO; r.exp_n = 1; r.exp0 = 8'h15; r.exp1 = 8'h00;
      end
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic ok;
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = rx_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 100);
      rx_valid = 1'b0;
      chk("rx_accept", ok, 1'b1);
   endtask

   task automatic clear_mon();
      rd_cyc = 0; we_cyc = 0; both_cnt = 0; unstable = 0; rxr_bad = 0; txhold_bad = 0;
      tx_q.delete();
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int n;
      clear_mon();
      rdy_at = v.rdy;
      dout_v = v.dout;
      if (v.garb) send_byte(8'h7F);
      send_byte(v.wr ? 8'h02 : 8'h01);
      send_byte(v.addr);
      if (v.wr) begin
         send_byte(v.data[15:8]);
         send_byte(v.data[7:0]);
      end
      // host keeps offering a non-command byte; it must not be taken while busy
      rx_data  = 8'h80 | 8'($urandom_range(0, 127));
      rx_valid = 1'b1;
      for (int k = 0; k < v.exp_n; k++) begin
         n = 0;
         while (!tx_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
         end
         chk({tag, " tx_wait"}, tx_valid, 1'b1);
         if (!tx_valid) break;
         repeat (v.stall) begin @(posedge clk); #1; end
         tx_ready = 1'b1;
         @(posedge clk); #1;
         tx_ready = 1'b0;
      end
      repeat (4) begin @(posedge clk); #1; end
      rx_valid = 1'b0;
      chk({tag, " tx_count"}, tx_q.size(), v.exp_n);
      if (tx_q.size() > 0) chk({tag, " tx_byte0"}, tx_q[0], v.exp0);
      if (tx_q.size() > 1 && v.exp_n > 1) chk({tag, " tx_byte1"}, tx_q[1], v.exp1);
      chk({tag, " rd_cycles"}, rd_cyc, v.wr ? 0 : v.exp_cyc);
      chk({tag, " we_cycles"}, we_cyc, v.wr ? v.exp_cyc : 0);
      chk({tag, " strobe_addr"}, a_seen, v.addr);
      if (v.wr) chk({tag, " strobe_wdata"}, di_seen, v.data);
      chk({tag, " rd_we_both"}, both_cnt, 0);
      chk({tag, " strobe_unstable"}, unstable, 0);
      chk({tag, " rx_ready_busy"}, rxr_bad, 0);
      chk({tag, " tx_hold"}, txhold_bad, 0);
      chk({tag, " busy_end"}, busy, 1'b0);
      chk({tag, " addr_kept"}, dbg_a, v.addr);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " dbg_a"}, dbg_a, 8'h00);
      chk({tag, " dbg_di"}, dbg_di, 16'h0000);
      chk({tag, " dbg_we"}, dbg_we, 1'b0);
      chk({tag, " dbg_rd"}, dbg_rd, 1'b0);
      chk({tag, " tx_valid"}, tx_valid, 1'b0);
      chk({tag, " tx_data"}, tx_data, 8'h00);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " rx_ready"}, rx_ready, 1'b1);
   endtask

   vec_t tbl[7];
   vec_t rv;

   initial begin
      tbl[0] = mk(1'b0, 8'h10, 16'h0000, 3, 16'hBEEF, 0, 1'b0, 2, 8'hBE, 8'hEF, 3);
      tbl[1] = mk(1'b1, 8'h1B, 16'h1234, 1, 16'h0000, 0, 1'b0, 1, 8'h06, 8'h00, 1);
      tbl[2] = mk(1'b0, 8'h30, 16'h0000, 0, 16'h9999, 0, 1'b0, 1, 8'h15, 8'h00, 4);
      tbl[3] = mk(1'b0, 8'h30, 16'h0000, 4, 16'hA55A, 0, 1'b0, 2, 8'hA5, 8'h5A, 4);
      tbl[4] = mk(1'b0, 8'h42, 16'h0000, 2, 16'hC3D2, 5, 1'b1, 2, 8'hC3, 8'hD2, 2);
      tbl[5] = mk(1'b1, 8'h77, 16'hFFFF, 0, 16'h0000, 2, 1'b0, 1, 8'h15, 8'h00, 4);
      tbl[6] = mk(1'b1, 8'h00, 16'h0001, 5, 16'h0000, 1, 1'b1, 1, 8'h15, 8'h00, 4);

      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_vals("por");

      for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 25; i++) begin
         rv.wr    = 1'($urandom_range(0, 1));
         rv.addr  = 8'($urandom);
         rv.data  = 16'($urandom);
         rv.rdy   = $urandom_range(0, TO + 2);
         rv.dout  = 16'($urandom);
         rv.stall = $urandom_range(0, 3);
         rv.garb  = 1'($urandom_range(0, 1));
         run_frame(model(rv), $sformatf("rnd%0d", i));
      end

      // reset while a write strobe is waiting on a responder that never answers
      clear_mon();
      rdy_at = 0;
      send_byte(8'h02); send_byte(8'h5A); send_byte(8'hAB); send_byte(8'hCD);
      chk("mid_bus we_high", dbg_we, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_vals("mid_bus");
      tx_ready = 1'b1;
      repeat (TO + 4) begin @(posedge clk); #1; end
      tx_ready = 1'b0;
      chk("mid_bus no_tx", tx_q.size(), 0);
      chk("mid_bus idle", busy, 1'b0);

      rv = mk(1'b0, 8'h66, 16'h0000, 2, 16'h1357, 1, 1'b0, 0, 8'h0, 8'h0, 0);
      run_frame(model(rv), "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
